// File: rtl/riscv_div_pkg.sv
// Shared types and constants for the RV32M iterative divide/remainder unit.
package riscv_div_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam int          DIV_ITERATIONS = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN        = 32'h8000_0000;

  // Magnitude of an operand; INT_MIN maps to unsigned 0x80000000.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      return 32'd0 - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH:0]   rem_o,
  output logic                  q_bit_o
);

  localparam int RW = DATA_WIDTH + 1;

  // Trial subtraction; keep the shifted remainder when the divisor does not fit.
  always_comb begin
    q_bit_o = 1'b0;
    rem_o   = '0;
    if ({rem_i, bit_i} >= {2'b00, divisor_i}) begin
      q_bit_o = 1'b1;
      rem_o   = RW'({rem_i, bit_i} - {2'b00, divisor_i});
    end else begin
      q_bit_o = 1'b0;
      rem_o   = RW'({rem_i, bit_i});
    end
  end

endmodule

// File: rtl/riscv_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
// Divide-by-zero and signed overflow resolve at accept and skip the iteration.
// Optional build macro DIV_EARLY_OUT_EN: operands with |SrcA| < |SrcB| also
// resolve at accept (quotient 0, remainder SrcA); results are unchanged.
module riscv_div_unit
  import riscv_div_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StartValid,
  output logic                  StartReady,
  input  logic [1:0]            DivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  ResultValid,
  input  logic                  ResultReady,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Busy
);

  div_state_t            state_q;
  logic                  is_rem_q;
  logic                  quo_neg_q;
  logic                  rem_neg_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH:0]   rem_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  result_valid_q;
  logic                  start_ready_q;
  logic                  busy_q;

  div_op_t               op_s;
  logic                  is_signed_s;
  logic                  is_rem_s;
  logic [DATA_WIDTH-1:0] a_mag_s;
  logic [DATA_WIDTH-1:0] b_mag_s;
  logic                  spec_hit_s;
  logic [DATA_WIDTH-1:0] spec_res_s;
  logic [DATA_WIDTH:0]   step_rem_s;
  logic                  step_q_s;
  logic [DATA_WIDTH-1:0] q_mag_s;
  logic [DATA_WIDTH-1:0] r_mag_s;
  logic [DATA_WIDTH-1:0] final_s;

  assign StartReady  = start_ready_q;
  assign ResultValid = result_valid_q;
  assign Result      = result_q;
  assign Busy        = busy_q;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DATA_WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_q_s)
  );

  // Decode the request and resolve the cases that need no iteration.
  always_comb begin
    op_s        = div_op_t'(DivOp);
    is_signed_s = (op_s == DIV_OP_DIV) || (op_s == DIV_OP_REM);
    is_rem_s    = (op_s == DIV_OP_REM) || (op_s == DIV_OP_REMU);
    a_mag_s     = div_mag(SrcA, is_signed_s);
    b_mag_s     = div_mag(SrcB, is_signed_s);
    spec_hit_s  = 1'b0;
    spec_res_s  = '0;
    if (SrcB == 32'd0) begin
      spec_hit_s = 1'b1;
      spec_res_s = is_rem_s ? SrcA : DIV_BY_ZERO_Q;
    end else if (is_signed_s && (SrcA == INT_MIN) && (SrcB == 32'hFFFF_FFFF)) begin
      spec_hit_s = 1'b1;
      spec_res_s = is_rem_s ? 32'd0 : INT_MIN;
`ifdef DIV_EARLY_OUT_EN
    end else if (a_mag_s < b_mag_s) begin
      spec_hit_s = 1'b1;
      spec_res_s = is_rem_s ? SrcA : 32'd0;
`endif
    end else begin
      spec_hit_s = 1'b0;
      spec_res_s = '0;
    end
  end

  // Sign-correct the magnitudes produced by the final iteration and pick the result.
  always_comb begin
    q_mag_s = {dvd_q[DATA_WIDTH-2:0], step_q_s};
    r_mag_s = step_rem_s[DATA_WIDTH-1:0];
    final_s = '0;
    if (is_rem_q) begin
      final_s = rem_neg_q ? (32'd0 - r_mag_s) : r_mag_s;
    end else begin
      final_s = quo_neg_q ? (32'd0 - q_mag_s) : q_mag_s;
    end
  end

  // Control FSM with the datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      is_rem_q       <= 1'b0;
      quo_neg_q      <= 1'b0;
      rem_neg_q      <= 1'b0;
      dvd_q          <= '0;
      dvs_q          <= '0;
      rem_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (StartValid && start_ready_q) begin
            is_rem_q      <= is_rem_s;
            quo_neg_q     <= is_signed_s && (SrcA[DATA_WIDTH-1] ^ SrcB[DATA_WIDTH-1]);
            rem_neg_q     <= is_signed_s && SrcA[DATA_WIDTH-1];
            dvd_q         <= a_mag_s;
            dvs_q         <= b_mag_s;
            rem_q         <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (spec_hit_s) begin
              state_q        <= DONE;
              result_q       <= spec_res_s;
              result_valid_q <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q <= {dvd_q[DATA_WIDTH-2:0], step_q_s};
          rem_q <= step_rem_s;
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(DIV_ITERATIONS - 1)) begin
            state_q        <= DONE;
            result_q       <= final_s;
            result_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (ResultReady) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          result_valid_q <= 1'b0;
          start_ready_q  <= 1'b1;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Iterative multi-cycle divider/remainder unit for the RV32M DIV, DIVU, REM and REMU operations.
- Sits beside the single-cycle combinational ALU in the execute stage. The ALU answers in the same cycle; this block answers over many cycles through a valid/ready request/response handshake.
- Uses a radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- StartValid  input  1  request valid.
- StartReady  output  1  unit can accept a request (high only in IDLE).
- DivOp  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- SrcA  input  DATA_WIDTH  dividend.
- SrcB  input  DATA_WIDTH  divisor.
- ResultValid  output  1  Result is valid.
- ResultReady  input  1  consumer accepts Result.
- Result  output  DATA_WIDTH  quotient or remainder, per DivOp.
- Busy  output  1  high in CALC or DONE.

Behaviour:
- Reset:
  - State goes to IDLE asynchronously.
  - StartReady=1, ResultValid=0, Busy=0, Result=0, internal registers cleared.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States and transitions:
  - IDLE: on StartValid&&StartReady, capture DivOp, SrcA, SrcB. Next state is DONE if a special case applies, else CALC. Inputs may change after the accept cycle.
  - CALC: one restoring step per cycle for exactly 32 cycles (counter 0..31). After the step with counter=31, go to DONE.
  - DONE: ResultValid=1, Result held stable. On ResultValid&&ResultReady, go to IDLE next cycle.
- Latency:
  - Normal case: ResultValid first high 33 cycles after the accept edge (accept = cycle 0).
  - Special cases: ResultValid high at cycle 1.
- Back-to-back: StartReady is 0 in DONE, so a new request is accepted no earlier than the cycle after the result handshake. StartValid outside IDLE is ignored.
- Signed ops (DIV/REM):
  - Divide the magnitudes.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitude of 0x80000000 is handled as unsigned 0x80000000 (a 33-bit internal remainder register is allowed).
- Special cases (resolved at accept, skip CALC):
  - Divide by zero: quotient=0xFFFFFFFF for DIV and DIVU; remainder=SrcA.
  - Signed overflow (SrcA=0x80000000, SrcB=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- Result selection: DIV/DIVU return the quotient; REM/REMU return the remainder. No exceptions or flags are raised.
- Simultaneous reset and handshake: reset wins.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at accept, if |SrcA| < |SrcB| (unsigned compare of the magnitudes) and SrcB≠0, go directly to DONE with quotient=0 and remainder=SrcA. Result is valid at cycle 1.
- Undefined: such operands take the full 33-cycle path; results are identical either way.
- The bench must pass with the macro both defined and undefined; only latency checks differ.

Decomposition:
- Shared package riscv_div_pkg:
  - typedef enum logic[1:0] div_op_t {DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU}.
  - typedef enum div_state_t {IDLE, CALC, DONE}.
  - Constants DIV_ITERATIONS=32, DIV_BY_ZERO_Q=32'hFFFFFFFF, INT_MIN=32'h80000000.
- Sub-module div_step (combinational, one restoring iteration):
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once and used iteratively by the top.

Test Plan:
- DIV 20/-3 (0x14, 0xFFFFFFFD) -> Result=0xFFFFFFFA at cycle 33; REM with the same operands -> 0x00000002; REM -7/2 -> 0xFFFFFFFF.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU with the same operands -> 0x00000001; both at cycle 33, Busy high cycles 1-33.
- DIV 7/0 -> 0xFFFFFFFF at cycle 1; REMU 7/0 -> 0x00000007 at cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0x00000000; both at cycle 1.
- Backpressure: hold ResultReady=0 for 10 cycles in DONE -> Result stable, StartReady=0, a pulsed StartValid is ignored. Raise ResultReady -> IDLE next cycle, StartReady=1.
- Assert reset at CALC cycle 15 -> ResultValid=0, Result=0, StartReady=1 immediately. After release, DIVU 100/7 -> 0x0000000E at cycle 33 (cycle 1 with DIV_EARLY_OUT_EN is not expected since 100>7).
